// File: rtl/dmem_ctrl.sv
// dmem_ctrl: RV32I data memory with a valid/ready request port, wait states,
// byte-lane stores, sign/zero-extended loads and fault reporting.
module dmem_ctrl #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state;
  logic [3:0] cnt;
  logic we_q;
  logic [2:0] f3_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] mem [DEPTH_WORDS];
  logic a_we, go, err;
  logic [2:0] f3;
  logic [31:0] a, wd, word, sh, ld, lanes, nw;
  logic [AW-1:0] idx;
  logic [3:0] be;
  // With zero wait states the access completes on the accept edge, so it must use the live request
  always_comb begin
    a_we = state == IDLE ? req_we : we_q;
    f3 = state == IDLE ? req_funct3 : f3_q;
    a = state == IDLE ? req_addr : addr_q;
    wd = state == IDLE ? req_wdata : wdata_q;
    go = state == IDLE ? req_valid && WAIT_CYCLES == 0 : state == WAIT && cnt == 4'd0;
    err = f3 == 3'b011 || f3[2:1] == 2'b11 || (a_we && f3[2]) || (f3[1:0] == 2'b01 && a[0])
          || (f3 == 3'b010 && a[1:0] != 2'b00) || a[31:AW+2] != '0;
    idx = a[AW+1:2];
    word = mem[idx];
    sh = word >> {a[1:0], 3'b000};
    ld = f3[1:0] == 2'b10 ? word : f3[0] ? {{16{sh[15] & ~f3[2]}}, sh[15:0]} : {{24{sh[7] & ~f3[2]}}, sh[7:0]};
    be = f3[1:0] == 2'b00 ? 4'b0001 << a[1:0] : f3[1:0] == 2'b01 ? 4'b0011 << {a[1], 1'b0} : 4'b1111;
    lanes = f3[1:0] == 2'b00 ? {4{wd[7:0]}} : f3[1:0] == 2'b01 ? {2{wd[15:0]}} : wd;
    nw = word;
    for (int i = 0; i < 4; i++) nw[8*i+:8] = be[i] ? lanes[8*i+:8] : word[8*i+:8];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      we_q <= 1'b0;
      f3_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else begin
      rsp_valid <= go;
      if (go) begin
        rsp_err <= err;
        rsp_rdata <= err || a_we ? '0 : ld;
        if (!err && a_we) mem[idx] <= nw;
      end
      case (state)
        IDLE: if (req_valid) begin
          we_q <= req_we;
          f3_q <= req_funct3;
          addr_q <= req_addr;
          wdata_q <= req_wdata;
          req_ready <= 1'b0;
          cnt <= 4'(WAIT_CYCLES - 1);
          state <= WAIT_CYCLES == 0 ? RESP : WAIT;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd0) state <= RESP;
        end
        RESP: begin
          state <= IDLE;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: scoreboard bench for dmem_ctrl with a byte-array reference memory
// plus two extra instances exercising zero and three wait states back to back.
module tb_dmem_ctrl;
  localparam int DEPTH = 256;
  localparam int W = 1;
  logic clk = 0, rst = 1, req_valid = 0, req_we = 0, cad_on = 0, cad_chk = 0;
  logic [2:0] req_funct3 = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  int checks = 0, fails = 0, cyc = 0;
  typedef struct {logic [31:0] d; logic e; int c;} exp_t;
  exp_t sb[$];
  exp_t mx;
  logic [7:0] mm [4*DEPTH];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  dmem_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err));

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // Reference: byte-addressed memory, access size 1<<funct3[1:0], extension by funct3[2]
  function automatic exp_t model(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
    exp_t r;
    int n;
    n = 1 << f3[1:0];
    r.e = f3 inside {3'd3, 3'd6, 3'd7} || (we && f3 inside {3'd4, 3'd5}) || ((f3 == 3'd1 || f3 == 3'd5) && addr[0])
          || (f3 == 3'd2 && addr % 4 != 0) || addr >= 4 * DEPTH;
    r.d = 0;
    r.c = 0;
    if (!r.e) for (int i = 0; i < n; i++) if (we) mm[addr+i] = wdata[8*i+:8]; else r.d[8*i+:8] = mm[addr+i];
    if (!r.e && !we && !f3[2] && n < 4 && r.d[8*n-1]) for (int i = n; i < 4; i++) r.d[8*i+:8] = 8'hFF;
    return r;
  endfunction

  always @(negedge clk) if (rsp_valid) begin
    if (sb.size() == 0) begin
      checks++;
      fails++;
      $display("FAIL unexpected_rsp: got rsp_valid=1 expected no pending request");
    end else begin
      mx = sb.pop_front();
      chk("rsp_rdata", rsp_rdata, mx.d);
      chk("rsp_err", {31'b0, rsp_err}, {31'b0, mx.e});
      chk("latency", cyc - mx.c, W + 1);
    end
  end

  task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic fixed, input logic [31:0] ed, input logic ee);
    exp_t r;
    int t = 0;
    @(posedge clk); #1;
    req_valid = 1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    do begin @(negedge clk); t++; end while (!req_ready && t < 50);
    if (!req_ready) begin
      chk("handshake_timeout", 0, 1);
      req_valid = 0;
      return;
    end
    r = model(we, f3, addr, wdata);
    if (fixed) begin r.d = ed; r.e = ee; end
    r.c = cyc;
    sb.push_back(r);
    @(posedge clk); #1;
    req_valid = 0; req_we = 1'($urandom); req_funct3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
    for (int i = 0; i <= W; i++) begin @(negedge clk); chk("req_ready_busy", {31'b0, req_ready}, 0); end
    @(negedge clk);
    chk("req_ready_idle", {31'b0, req_ready}, 1);
  endtask

  for (genvar g = 0; g < 2; g++) begin : cad
    localparam int WC = g * 3;
    logic ready_c, valid_c, err_c;
    logic [31:0] rd_c;
    int last = -1, pulses = 0, acc = 0;
    dmem_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WC)) u (
      .clk(clk), .rst(rst), .req_valid(cad_on), .req_ready(ready_c), .req_we(1'b0),
      .req_funct3(3'b010), .req_addr(32'h10), .req_wdata(32'h0),
      .rsp_valid(valid_c), .rsp_rdata(rd_c), .rsp_err(err_c));
    always @(negedge clk) begin
      if (cad_on && ready_c) acc++;
      if (valid_c) begin
        pulses++;
        if (last >= 0) chk("cadence", cyc - last, WC + 2);
        chk("cad_rdata", {rd_c[31:1], rd_c[0] | err_c}, 0);
        last = cyc;
      end
      if (cad_chk) begin
        chk("cad_pulses", pulses, acc);
        chk("cad_accepts", {31'b0, acc > 4}, 1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4 * DEPTH; i++) mm[i] = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_ready", {31'b0, req_ready}, 1);
    chk("rst_valid", {31'b0, rsp_valid}, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", {31'b0, rsp_err}, 0);
    @(posedge clk); #1 cad_on = 1;
    repeat (30) @(posedge clk);
    #1 cad_on = 0;
    repeat (8) @(posedge clk);
    #1 cad_chk = 1;
    @(posedge clk); #1 cad_chk = 0;
    send(0, 3'b010, 32'h10, 0, 1, 32'h0, 0);
    send(1, 3'b010, 32'h20, 32'h80F0A55A, 1, 32'h0, 0);
    send(0, 3'b000, 32'h23, 0, 1, 32'hFFFFFF80, 0);
    send(0, 3'b100, 32'h23, 0, 1, 32'h00000080, 0);
    send(0, 3'b001, 32'h20, 0, 1, 32'hFFFFA55A, 0);
    send(0, 3'b101, 32'h22, 0, 1, 32'h000080F0, 0);
    send(1, 3'b010, 32'h40, 32'h11223344, 1, 32'h0, 0);
    send(1, 3'b000, 32'h41, 32'hFFFFFFAA, 1, 32'h0, 0);
    send(1, 3'b001, 32'h42, 32'h1234BEEF, 1, 32'h0, 0);
    send(0, 3'b010, 32'h40, 0, 1, 32'hBEEFAA44, 0);
    send(0, 3'b010, 32'h22, 0, 1, 32'h0, 1);
    send(1, 3'b001, 32'h21, 32'h5555, 1, 32'h0, 1);
    send(0, 3'b010, 32'h20, 0, 1, 32'h80F0A55A, 0);
    send(0, 3'b010, 32'h400, 0, 1, 32'h0, 1);
    send(0, 3'b011, 32'h0, 0, 1, 32'h0, 1);
    send(1, 3'b100, 32'h4, 32'h77, 1, 32'h0, 1);
    @(posedge clk); #1;
    req_valid = 1; req_we = 1; req_funct3 = 3'b010; req_addr = 32'h8; req_wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("pre_rst_ready", {31'b0, req_ready}, 1);
    @(posedge clk); #1;
    req_valid = 0; rst = 1;
    for (int i = 0; i < 3; i++) begin @(negedge clk); chk("rst_no_rsp", {31'b0, rsp_valid}, 0); end
    @(posedge clk); #1 rst = 0;
    for (int i = 0; i < 4 * DEPTH; i++) mm[i] = 0;
    @(negedge clk);
    chk("post_rst_ready", {31'b0, req_ready}, 1);
    chk("post_rst_valid", {31'b0, rsp_valid}, 0);
    send(0, 3'b010, 32'h8, 0, 1, 32'h0, 0);
    send(0, 3'b010, 32'h20, 0, 0, 0, 0);
    repeat (150) begin
      int k;
      logic [31:0] ad;
      k = $urandom_range(0, 7);
      ad = k < 5 ? $urandom_range(0, 63) : k < 7 ? $urandom_range(0, 4 * DEPTH + 7) : $urandom;
      send(1'($urandom), 3'($urandom), ad, $urandom, 0, 0, 0);
    end
    repeat (W + 4) @(negedge clk);
    chk("sb_drain", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
Parametrised RV32I data memory with a valid/ready request port and a pulsed response port. Supports all RV32I load/store widths (LB/LH/LW/LBU/LHU, SB/SH/SW) with byte-lane writes and sign/zero extension. Flags misaligned, out-of-range and illegal-width accesses. Configurable wait states model slower memory behind the load/store stage of the core.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words; power of two, >= 4
WAIT_CYCLES, 1, extra cycles between request accept and response; 0..15

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
req_valid  input  1  request present
req_ready  output  1  block can accept a request
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned
rsp_valid  output  1  one-cycle response pulse
rsp_rdata  output  32  extended load data; 0 for stores and errors
rsp_err  output  1  access faulted; valid only with rsp_valid

Behaviour:
- Reset (asynchronous): all memory words cleared to 0; FSM to IDLE; wait counter 0; req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On req_valid, latch we/funct3/addr/wdata. Go to WAIT with counter = WAIT_CYCLES-1 if WAIT_CYCLES>0, else go to RESP.
  - WAIT: req_ready=0. Counter decrements each cycle. At 0, go to RESP.
  - RESP: rsp_valid=1 for exactly one cycle, req_ready=0, then return to IDLE.
- No response backpressure; the consumer must take rsp_* in the RESP cycle.
- Latency: req accepted at edge N gives rsp_valid high in cycle N+WAIT_CYCLES+1. Back-to-back throughput is one request per WAIT_CYCLES+2 cycles.
- Memory write and read-data capture happen on the clock edge entering RESP. rsp_rdata/rsp_err are registered and held until the next RESP.
- Word index = addr[log2(DEPTH_WORDS)+1:2]. Out-of-range when addr >= 4*DEPTH_WORDS.
- Error conditions, checked in this order (any one sets rsp_err=1):
  - funct3 in {011, 110, 111}
  - store with funct3 BU/HU
  - H/HU with addr[0]=1
  - W with addr[1:0]!=0
  - out-of-range
- On error: no memory update, rsp_rdata=0.
- Stores:
  - SB writes byte lane addr[1:0] with wdata[7:0].
  - SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0], little-endian.
  - SW writes all four lanes.
  - Unwritten lanes are preserved. Stores return rsp_rdata=0, rsp_err=0.
- Loads:
  - Byte/halfword is selected by addr[1:0], little-endian.
  - B/H sign-extend to 32; BU/HU zero-extend; W is the raw word.
- req_valid while req_ready=0 is ignored (no latch); the requester must hold req_valid until the handshake.
- Reset mid-operation (WAIT or RESP): pending access is abandoned, no memory write, no rsp_valid pulse.
- Inputs are sampled only at the accept edge; later changes to req_* do not affect the in-flight access.

Test Plan:
- Reset, then LW at 0x10 with WAIT_CYCLES=1: req accepted edge 0 -> rsp_valid in cycle 2, rsp_rdata=0x00000000, rsp_err=0; req_ready low in cycles 1-2.
- SW 0x80F0A55A at 0x20, then LB 0x23, LBU 0x23, LH 0x20, LHU 0x22 -> 0xFFFFFF80, 0x00000080, 0xFFFFA55A, 0x000080F0.
- SW 0x11223344 at 0x40, SB 0xAA at 0x41, SH 0xBEEF at 0x42, then LW 0x40 -> 0xBEEFAA44.
- Faults:
  - LW at 0x22 -> rsp_err=1, rsp_rdata=0.
  - SH at 0x21 -> rsp_err=1; LW at 0x20 then shows memory unchanged.
  - LW at 0x400 (DEPTH_WORDS=256) -> rsp_err=1.
  - funct3=011 -> rsp_err=1.
- WAIT_CYCLES=0 vs 3: back-to-back LWs held on req_valid -> rsp_valid every 2 and 5 cycles respectively; exactly one pulse per accepted request.
- Assert rst during WAIT of SW 0xDEADBEEF at 0x8 -> no rsp_valid. After release: req_ready=1, and LW 0x8 returns 0x00000000.
